// File: rtl/xbar_route_sequencer.sv
// xbar_route_sequencer
//   Initiator for a crossbar control channel. A small route table holds
//   (input select, output select, transfer count) per entry. Each active entry
//   is issued as a control word. The route is then held until the programmed
//   number of routed-output fires (fed back on xfer_fire) have completed, and
//   then the next entry is issued.
//
//   Build option: define XBAR_SEQ_LOOP_EN to wrap back to entry 0 after the
//   last active entry. Sequencing then repeats until stop, and done pulses once
//   per pass. Without it, the sequencer returns to IDLE with a done pulse.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   cfg_we/cfg_addr/cfg_in_sel/cfg_out_sel/cfg_count   route table write
//   cfg_len_we/cfg_len number of active entries (saturated to N_ENTRIES)
//   start, stop        begin at entry 0 / abort
//   xfer_fire          one completed transfer on the active route
//   control, control_val, control_rdy   control channel to the crossbar
//   busy, cur_entry    status
//   done, cfg_err      one-cycle pulses
//
// state  | meaning
// IDLE   | table writable, waiting for start
// ISSUE  | control word presented, waiting for control_rdy
// HOLD   | route held, counting xfer_fire up to the entry count
module xbar_route_sequencer #(
  parameter int N_INPUTS          = 2,
  parameter int N_OUTPUTS         = 2,
  parameter int CONTROL_BIT_WIDTH = 42,
  parameter int N_ENTRIES         = 4,
  parameter int COUNT_WIDTH       = 16,
  localparam int LI = $clog2(N_INPUTS),
  localparam int LO = $clog2(N_OUTPUTS),
  localparam int AW = $clog2(N_ENTRIES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_we,
  input  logic [AW-1:0]                cfg_addr,
  input  logic [LI-1:0]                cfg_in_sel,
  input  logic [LO-1:0]                cfg_out_sel,
  input  logic [COUNT_WIDTH-1:0]       cfg_count,
  input  logic                         cfg_len_we,
  input  logic [AW:0]                  cfg_len,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         xfer_fire,
  output logic [CONTROL_BIT_WIDTH-1:0] control,
  output logic                         control_val,
  input  logic                         control_rdy,
  output logic                         busy,
  output logic [AW-1:0]                cur_entry,
  output logic                         done,
  output logic                         cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(N_ENTRIES);

  logic [LI-1:0]          r_tbl_in  [N_ENTRIES];
  logic [LO-1:0]          r_tbl_out [N_ENTRIES];
  logic [COUNT_WIDTH-1:0] r_tbl_cnt [N_ENTRIES];
  logic [AW:0]            r_len;

  state_t                         r_state, w_state_nxt;
  logic [AW-1:0]                  r_cur, w_cur_nxt;
  logic [COUNT_WIDTH-1:0]         r_cnt, w_cnt_nxt;
  logic [CONTROL_BIT_WIDTH-1:0]   r_control, w_word;
  logic                           r_control_val, r_done, r_cfg_err;
  logic                           w_done_nxt, w_err_nxt, w_cfg_wr, w_len_wr, w_adv;
  logic [COUNT_WIDTH-1:0]         w_cur_cnt, w_cnt_inc;
  logic [AW:0]                    w_cur_ext;
  logic                           w_last;

  assign w_cur_cnt = r_tbl_cnt[r_cur];
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_cur_ext = {1'b0, r_cur} + 1'b1;
  assign w_last    = (w_cur_ext >= r_len);

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_cfg_wr    = 1'b0;
    w_len_wr    = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cfg_wr = cfg_we;
        w_len_wr = cfg_len_we;
        if (start && !stop) begin
          if (r_len != '0) begin
            w_state_nxt = S_ISSUE;
            w_cur_nxt   = '0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (control_rdy) begin
          w_cnt_nxt = '0;
          if (w_cur_cnt == '0) w_adv = 1'b1;
          else                 w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (xfer_fire) begin
          if (w_cnt_inc == w_cur_cnt) w_adv = 1'b1;
          else                        w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_adv) begin
      w_cnt_nxt = '0;
      if (!w_last) begin
        w_cur_nxt   = r_cur + 1'b1;
        w_state_nxt = S_ISSUE;
      end else begin
        w_cur_nxt  = '0;
        w_done_nxt = 1'b1;
`ifdef XBAR_SEQ_LOOP_EN
        w_state_nxt = S_ISSUE;
`else
        w_state_nxt = S_IDLE;
`endif
      end
    end

    // Outside IDLE, config writes are rejected; stop overrides any advance.
    if (r_state != S_IDLE) begin
      if (cfg_we || cfg_len_we) w_err_nxt = 1'b1;
      if (stop) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_cur_nxt   = '0;
        w_done_nxt  = 1'b0;
      end
    end
  end

  // Word for the entry that will be presented next cycle, so control is registered.
  always_comb begin
    w_word = '0;
    w_word[CONTROL_BIT_WIDTH-1 -: LI]    = r_tbl_in[w_cur_nxt];
    w_word[CONTROL_BIT_WIDTH-1-LI -: LO] = r_tbl_out[w_cur_nxt];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cur         <= '0;
      r_cnt         <= '0;
      r_control     <= '0;
      r_control_val <= 1'b0;
      r_done        <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_len         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cur         <= w_cur_nxt;
      r_cnt         <= w_cnt_nxt;
      r_control_val <= (w_state_nxt == S_ISSUE);
      r_control     <= (w_state_nxt == S_ISSUE) ? w_word : '0;
      r_done        <= w_done_nxt;
      r_cfg_err     <= w_err_nxt;
      if (w_len_wr) r_len <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        r_tbl_in[i]  <= '0;
        r_tbl_out[i] <= '0;
        r_tbl_cnt[i] <= '0;
      end
    end else if (w_cfg_wr) begin
      r_tbl_in[cfg_addr]  <= cfg_in_sel;
      r_tbl_out[cfg_addr] <= cfg_out_sel;
      r_tbl_cnt[cfg_addr] <= cfg_count;
    end
  end

  assign control     = r_control;
  assign control_val = r_control_val;
  assign busy        = (r_state != S_IDLE);
  assign cur_entry   = r_cur;
  assign done        = r_done;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_xbar_route_sequencer.sv
// Testbench for xbar_route_sequencer: directed scenarios plus randomized route
// tables, checked against a table-level reference model and an accept scoreboard.
module tb_xbar_route_sequencer;
  localparam int CW = 42;
  localparam int NE = 4;
  localparam int AW = 2;
  localparam int CNTW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_we = 1'b0, cfg_len_we = 1'b0, start = 1'b0, stop = 1'b0;
  logic xfer_fire = 1'b0, control_rdy = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic cfg_in_sel = 1'b0, cfg_out_sel = 1'b0;
  logic [CNTW-1:0] cfg_count = '0;
  logic [AW:0] cfg_len = '0;
  logic [CW-1:0] control;
  logic control_val, busy, done, cfg_err;
  logic [AW-1:0] cur_entry;

  always #5 clk = ~clk;

  xbar_route_sequencer dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_in_sel(cfg_in_sel),
    .cfg_out_sel(cfg_out_sel), .cfg_count(cfg_count),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
    .start(start), .stop(stop), .xfer_fire(xfer_fire),
    .control(control), .control_val(control_val), .control_rdy(control_rdy),
    .busy(busy), .cur_entry(cur_entry), .done(done), .cfg_err(cfg_err)
  );

  int n_checks = 0, n_errors = 0;
  int mon_done = 0, mon_err = 0, exp_done = 0, exp_err = 0;
  logic [CW-1:0] exp_q [$];

  // Reference model: the route table as the user programmed it.
  int m_in [NE], m_out [NE], m_cnt [NE];
  int m_len = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Input select occupies the top bit, output select the next one.
  function automatic logic [CW-1:0] mword(input int in_sel, input int out_sel);
    logic [CW-1:0] w;
    w = (CW'(in_sel) << (CW - 1)) | (CW'(out_sel) << (CW - 2));
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_entry(input int a, input int i, input int o, input int c);
    cfg_addr = AW'(a); cfg_in_sel = i[0]; cfg_out_sel = o[0]; cfg_count = CNTW'(c);
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    m_in[a] = i; m_out[a] = o; m_cnt[a] = c;
  endtask

  task automatic cfg_setlen(input int v);
    cfg_len = (AW+1)'(v);
    cfg_len_we = 1'b1;
    tick();
    cfg_len_we = 1'b0;
    m_len = (v > NE) ? NE : v;
  endtask

  task automatic entry_end(input int i);
    if (i < m_len - 1) begin
      chk("next_val", control_val, 1);
      chk("next_entry", cur_entry, i + 1);
      chk("next_word", control, mword(m_in[i+1], m_out[i+1]));
      chk("next_done", done, 0);
    end else begin
`ifdef XBAR_SEQ_LOOP_EN
      chk("wrap_done", done, 1);
      chk("wrap_val", control_val, 1);
      chk("wrap_entry", cur_entry, 0);
      chk("wrap_word", control, mword(m_in[0], m_out[0]));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("loop_stop_busy", busy, 0);
      chk("loop_stop_val", control_val, 0);
`else
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_val", control_val, 0);
      chk("end_entry", cur_entry, 0);
      tick();
      chk("done_pulse_width", done, 0);
`endif
    end
  endtask

  task automatic run_seq(input int dmin, input int dmax);
    int d, g;
    if (m_len == 0) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_err++;
      chk("len0_err", cfg_err, 1);
      chk("len0_busy", busy, 0);
      chk("len0_val", control_val, 0);
      tick();
      chk("len0_err_width", cfg_err, 0);
      return;
    end
    for (int i = 0; i < m_len; i++) exp_q.push_back(mword(m_in[i], m_out[i]));
    exp_done++;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_val", control_val, 1);
    chk("start_entry", cur_entry, 0);
    chk("start_word", control, mword(m_in[0], m_out[0]));
    for (int i = 0; i < m_len; i++) begin
      d = $urandom_range(dmax, dmin);
      repeat (d) begin
        tick();
        chk("wait_rdy_val", control_val, 1);
      end
      control_rdy = 1'b1;
      tick();
      control_rdy = 1'b0;
      if (m_cnt[i] != 0) begin
        chk("hold_val", control_val, 0);
        chk("hold_busy", busy, 1);
        for (int k = 1; k <= m_cnt[i]; k++) begin
          g = $urandom_range(2, 0);
          repeat (g) begin
            tick();
            chk("hold_gap_val", control_val, 0);
          end
          xfer_fire = 1'b1;
          tick();
          xfer_fire = 1'b0;
          if (k < m_cnt[i]) begin
            chk("hold_fire_val", control_val, 0);
            chk("hold_fire_busy", busy, 1);
          end
        end
      end
      entry_end(i);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted control word, checks that a
  // pending word is stable while not accepted, and counts pulses.
  logic p_val = 1'b0, p_rdy = 1'b0, p_stop = 1'b0;
  logic [CW-1:0] p_word = '0;
  always @(negedge clk) begin
    if (reset) begin
      p_val = 1'b0;
    end else begin
      if (!control_val) chk("ctl_zero_no_val", control, 0);
      if (p_val && !p_rdy && !p_stop) begin
        chk("issue_val_stable", control_val, 1);
        chk("issue_word_stable", control, p_word);
      end
      if (control_val && control_rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_accept: got %0h expected none at %0t", control, $time);
        end else begin
          chk("accept_word", control, exp_q.pop_front());
        end
      end
      if (done) mon_done++;
      if (cfg_err) mon_err++;
      p_val = control_val; p_rdy = control_rdy; p_stop = stop; p_word = control;
    end
  end

  initial begin
    for (int i = 0; i < NE; i++) begin m_in[i] = 0; m_out[i] = 0; m_cnt[i] = 0; end
    #12;
    chk("rst_val", control_val, 0);
    chk("rst_ctl", control, 0);
    chk("rst_busy", busy, 0);
    chk("rst_entry", cur_entry, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);
    reset = 1'b0;
    tick();

    // len = 0 start is rejected
    run_seq(0, 0);

    // single entry, three fires
    cfg_entry(0, 1, 0, 3);
    cfg_setlen(1);
    run_seq(0, 0);

    // rdy held low for exactly 5 cycles
    cfg_entry(0, 0, 1, 2);
    run_seq(5, 5);

    // two entries, second needs no fires
    cfg_entry(1, 1, 1, 0);
    cfg_setlen(2);
    run_seq(0, 2);

    // stop beats start in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("stop_beats_start_busy", busy, 0);
    chk("stop_beats_start_err", cfg_err, 0);

    // abort in HOLD, ignored start, rejected cfg write
    cfg_entry(0, 1, 1, 3);
    cfg_setlen(1);
    exp_q.push_back(mword(1, 1));
    start = 1'b1;
    tick();
    start = 1'b0;
    control_rdy = 1'b1;
    tick();
    control_rdy = 1'b0;
    chk("abort_hold_val", control_val, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_ignored", busy, 1);
    chk("busy_start_no_err", cfg_err, 0);
    xfer_fire = 1'b1;
    tick();
    xfer_fire = 1'b0;
    chk("abort_after_fire_val", control_val, 0);
    cfg_addr = '0; cfg_in_sel = 1'b0; cfg_out_sel = 1'b0; cfg_count = CNTW'(1);
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    exp_err++;
    chk("busy_cfg_err", cfg_err, 1);
    cfg_len = '0; cfg_len_we = 1'b1;
    tick();
    cfg_len_we = 1'b0;
    exp_err++;
    chk("busy_len_err", cfg_err, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    chk("stop_val", control_val, 0);
    run_seq(0, 1);

    // len saturation
    cfg_entry(2, 0, 0, 1);
    cfg_entry(3, 1, 0, 2);
    cfg_setlen(7);
    run_seq(0, 2);

    // randomized tables
    for (int it = 0; it < 20; it++) begin
      for (int e = 0; e < NE; e++)
        cfg_entry(e, $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(3, 0));
      cfg_setlen($urandom_range(7, 0));
      run_seq(0, 3);
    end

    // asynchronous reset mid-ISSUE
    cfg_entry(0, 1, 1, 1);
    cfg_setlen(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pre_rst_val", control_val, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_val", control_val, 0);
    chk("async_rst_ctl", control, 0);
    chk("async_rst_busy", busy, 0);
    exp_q.delete();
    for (int i = 0; i < NE; i++) begin m_in[i] = 0; m_out[i] = 0; m_cnt[i] = 0; end
    m_len = 0;
    #3 reset = 1'b0;
    tick();
    run_seq(0, 0);

    repeat (3) tick();
    chk("done_pulse_count", mon_done, exp_done);
    chk("err_pulse_count", mon_err, exp_err);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
